// File: rtl/led_sequencer.sv
// led_sequencer: shares one status LED between a heartbeat, a one-shot
// error-code blinker and an 8-slot user pattern. All timing is in slot ticks
// produced by a free-running prescaler on the fabric clock.
//
//   state     | meaning
//   ----------+--------------------------------------------------------
//   S_IDLE    | heartbeat shown (if hb_en), arbitration on each tick
//   S_ERR_ON  | error pulse, LED on for 2 ticks
//   S_ERR_OFF | error pulse, LED off for 2 ticks
//   S_ERR_GAP | forced-off gap after the last error pulse
//   S_PAT     | user pattern, one bit per tick, MSB first
module led_sequencer #(
   parameter int TICK_DIV = 2400000,
   parameter int HB_HALF  = 5,
   parameter int ERR_GAP  = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       hb_en,
   input  logic       err_req,
   input  logic [3:0] err_count,
   output logic       err_ack,
   input  logic       pat_req,
   input  logic [7:0] pat_bits,
   output logic       pat_ack,
   output logic       busy,
   output logic       led
);

   localparam int PW   = $clog2(TICK_DIV);
   localparam int PHW  = $clog2(2 * HB_HALF);
   localparam int TMAX = (ERR_GAP > 8) ? ERR_GAP : 8;
   localparam int TW   = $clog2(TMAX);

   typedef enum logic [2:0] {
      S_IDLE, S_ERR_ON, S_ERR_OFF, S_ERR_GAP, S_PAT
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [PHW-1:0]  phase_q, phase_d, phase_nxt;
   logic [TW-1:0]   tcnt_q, tcnt_d;
   logic [3:0]      pulse_q, pulse_d;
   logic [7:0]      pat_q, pat_d;
   logic            led_q, led_d;
   logic            busy_q, busy_d;
   logic            err_ack_q, err_ack_d;
   logic            pat_ack_q, pat_ack_d;
   logic            err_grant, pat_grant;
   logic            tick;

   assign tick      = (presc_q == PW'(TICK_DIV - 1));
   assign phase_nxt = (phase_q == PHW'(2 * HB_HALF - 1)) ? '0 : phase_q + 1'b1;

   // State and output registers; everything clears on synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         presc_q   <= '0;
         phase_q   <= '0;
         tcnt_q    <= '0;
         pulse_q   <= '0;
         pat_q     <= '0;
         led_q     <= 1'b0;
         busy_q    <= 1'b0;
         err_ack_q <= 1'b0;
         pat_ack_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         phase_q   <= phase_d;
         tcnt_q    <= tcnt_d;
         pulse_q   <= pulse_d;
         pat_q     <= pat_d;
         led_q     <= led_d;
         busy_q    <= busy_d;
         err_ack_q <= err_ack_d;
         pat_ack_q <= pat_ack_d;
      end
   end

   // Next state: prescaler, arbitration in IDLE and slot counting, all on ticks.
   always_comb begin
      state_d   = state_q;
      presc_d   = tick ? '0 : presc_q + 1'b1;
      phase_d   = phase_q;
      tcnt_d    = tcnt_q;
      pulse_d   = pulse_q;
      pat_d     = pat_q;
      err_grant = 1'b0;
      pat_grant = 1'b0;
      if (tick) begin
         case (state_q)
            S_IDLE: begin
               if (err_req) begin
                  err_grant = 1'b1;
                  if (err_count == 4'd0) begin
                     // Empty error code: acknowledge but keep the heartbeat running.
                     phase_d = phase_nxt;
                  end else begin
                     state_d = S_ERR_ON;
                     pulse_d = err_count;
                     tcnt_d  = TW'(1);
                  end
               end else if (pat_req) begin
                  pat_grant = 1'b1;
                  state_d   = S_PAT;
                  pat_d     = pat_bits;
                  tcnt_d    = TW'(7);
               end else begin
                  phase_d = phase_nxt;
               end
            end
            S_ERR_ON: begin
               if (tcnt_q == '0) begin
                  state_d = S_ERR_OFF;
                  tcnt_d  = TW'(1);
               end else begin
                  tcnt_d = tcnt_q - 1'b1;
               end
            end
            S_ERR_OFF: begin
               if (tcnt_q == '0) begin
                  if (pulse_q == 4'd1) begin
                     state_d = S_ERR_GAP;
                     tcnt_d  = TW'(ERR_GAP - 1);
                  end else begin
                     state_d = S_ERR_ON;
                     pulse_d = pulse_q - 1'b1;
                     tcnt_d  = TW'(1);
                  end
               end else begin
                  tcnt_d = tcnt_q - 1'b1;
               end
            end
            S_ERR_GAP: begin
               if (tcnt_q == '0) begin
                  state_d = S_IDLE;
                  phase_d = '0;
               end else begin
                  tcnt_d = tcnt_q - 1'b1;
               end
            end
            S_PAT: begin
               if (tcnt_q == '0) begin
                  state_d = S_IDLE;
                  phase_d = '0;
               end else begin
                  tcnt_d = tcnt_q - 1'b1;
                  pat_d  = {pat_q[6:0], 1'b0};
               end
            end
            default: begin
               state_d = S_IDLE;
               phase_d = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so the LED changes one cycle after a tick.
   always_comb begin
      led_d     = 1'b0;
      busy_d    = (state_d != S_IDLE);
      err_ack_d = err_grant;
      pat_ack_d = pat_grant;
      case (state_d)
         S_IDLE:   led_d = hb_en && (phase_d < PHW'(HB_HALF));
         S_ERR_ON: led_d = 1'b1;
         S_PAT:    led_d = pat_d[7];
         default:  led_d = 1'b0;
      endcase
   end

   assign led     = led_q;
   assign busy    = busy_q;
   assign err_ack = err_ack_q;
   assign pat_ack = pat_ack_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer with a short prescaler: a timeline model predicts the
// registered outputs for the next cycle, pushes them to a scoreboard queue, and
// the entry is popped and compared after the following clock edge.
module tb_led_sequencer;

   localparam int TD = 4;
   localparam int HB = 5;
   localparam int EG = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       hb_en = 1'b1;
   logic       err_req = 1'b0;
   logic [3:0] err_count = 4'd0;
   logic       pat_req = 1'b0;
   logic [7:0] pat_bits = 8'd0;
   logic       err_ack, pat_ack, busy, led;

   always #5 clk = ~clk;

   led_sequencer #(.TICK_DIV(TD), .HB_HALF(HB), .ERR_GAP(EG)) dut (
      .clk(clk), .reset(reset), .hb_en(hb_en),
      .err_req(err_req), .err_count(err_count), .err_ack(err_ack),
      .pat_req(pat_req), .pat_bits(pat_bits), .pat_ack(pat_ack),
      .busy(busy), .led(led)
   );

   typedef struct {
      logic led;
      logic busy;
      logic eack;
      logic pack;
   } exp_t;

   exp_t sb[$];
   int   vec_cnt = 0;
   int   miss_cnt = 0;
   int   busy_cnt = 0, eack_cnt = 0, pack_cnt = 0;

   // timeline model: prescaler phase, mode (0 idle, 1 error, 2 pattern),
   // ticks since grant, ticks since entering idle
   int         pm = 0;
   int         mmode = 0;
   int         seq_t = 0;
   int         m_n = 0;
   logic [7:0] m_bits = 8'd0;
   int         hb_t = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         miss_cnt++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_push();
      exp_t e;
      bit   tk;
      e = '{led: 1'b0, busy: 1'b0, eack: 1'b0, pack: 1'b0};
      if (reset) begin
         pm    = 0;
         mmode = 0;
         hb_t  = 0;
      end else begin
         tk = (pm == TD - 1);
         pm = tk ? 0 : pm + 1;
         if (mmode == 0) begin
            if (tk) begin
               if (err_req) begin
                  e.eack = 1'b1;
                  if (err_count == 4'd0) hb_t++;
                  else begin
                     mmode = 1;
                     m_n   = int'(err_count);
                     seq_t = 0;
                  end
               end else if (pat_req) begin
                  e.pack = 1'b1;
                  mmode  = 2;
                  m_bits = pat_bits;
                  seq_t  = 0;
               end else begin
                  hb_t++;
               end
            end
         end else if (tk) begin
            seq_t++;
            if (seq_t == ((mmode == 1) ? 4 * m_n + EG : 8)) begin
               mmode = 0;
               hb_t  = 0;
            end
         end
         e.busy = (mmode != 0);
         case (mmode)
            0:       e.led = hb_en && ((hb_t % (2 * HB)) < HB);
            1:       e.led = (seq_t < 4 * m_n) && ((seq_t % 4) < 2);
            default: e.led = m_bits[7 - seq_t];
         endcase
      end
      sb.push_back(e);
   endtask

   task automatic step();
      exp_t e;
      model_push();
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk("led", led, e.led);
      chk("busy", busy, e.busy);
      chk("err_ack", err_ack, e.eack);
      chk("pat_ack", pat_ack, e.pack);
      if (busy === 1'b1) busy_cnt++;
      if (err_ack === 1'b1) eack_cnt++;
      if (pat_ack === 1'b1) pack_cnt++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clr();
      busy_cnt = 0;
      eack_cnt = 0;
      pack_cnt = 0;
   endtask

   task automatic wait_ack(input bit is_err, input int budget, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!((is_err ? err_ack : pat_ack) === 1'b1) && n < budget);
      if (is_err) chk("err_ack_seen", err_ack, 1);
      else        chk("pat_ack_seen", pat_ack, 1);
   endtask

   initial begin
      int n;

      // reset and heartbeat, including a stretch with hb_en low
      run(5);
      reset = 1'b0;
      clr();
      run(45);
      hb_en = 1'b0;
      run(10);
      hb_en = 1'b1;
      run(10);
      chk("hb_busy_cycles", busy_cnt, 0);

      // error blink, count 3
      clr();
      err_count = 4'd3;
      err_req   = 1'b1;
      wait_ack(1'b1, 8, n);
      err_req   = 1'b0;
      err_count = 4'd0;
      run(90);
      chk("err_ack_pulses", eack_cnt, 1);
      chk("err_busy_cycles", busy_cnt, 4 * 3 * TD + EG * TD);

      // pattern 1011_0010
      clr();
      pat_bits = 8'b1011_0010;
      pat_req  = 1'b1;
      wait_ack(1'b0, 8, n);
      pat_req  = 1'b0;
      pat_bits = 8'h00;
      run(40);
      chk("pat_ack_pulses", pack_cnt, 1);
      chk("pat_busy_cycles", busy_cnt, 8 * TD);

      // simultaneous requests: error wins, pattern follows the first idle tick
      clr();
      err_count = 4'd2;
      pat_bits  = 8'b1100_0101;
      err_req   = 1'b1;
      pat_req   = 1'b1;
      wait_ack(1'b1, 8, n);
      err_req = 1'b0;
      n = 0;
      do begin
         step();
         n++;
      end while (busy === 1'b1 && n < 100);
      chk("prio_busy_fell", busy, 0);
      chk("prio_no_pat_ack", pack_cnt, 0);
      chk("prio_err_busy", busy_cnt, 4 * 2 * TD + EG * TD);
      wait_ack(1'b0, 10, n);
      chk("prio_pat_delay", n, TD);
      pat_req = 1'b0;
      run(40);

      // zero count: ack only, heartbeat continues
      clr();
      err_count = 4'd0;
      err_req   = 1'b1;
      wait_ack(1'b1, 8, n);
      err_req = 1'b0;
      run(30);
      chk("zero_busy_cycles", busy_cnt, 0);
      chk("zero_ack_pulses", eack_cnt, 1);

      // reset during pattern slot 3 with the request still held
      pat_bits = 8'b1011_0010;
      pat_req  = 1'b1;
      wait_ack(1'b0, 8, n);
      run(13);
      chk("mid_slot3_led", led, 1);
      reset = 1'b1;
      step();
      chk("mid_rst_led", led, 0);
      chk("mid_rst_busy", busy, 0);
      reset = 1'b0;
      wait_ack(1'b0, 10, n);
      chk("mid_reack_delay", n, TD);
      pat_req = 1'b0;
      run(40);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
